// File: rtl/eth_phy_10g_rx_reset_ctrl_pkg.sv
// Shared definitions for the 10G PHY SERDES RX reset sequencer: state encodings,
// statistics counter width and a saturating increment helper.
package eth_phy_10g_rx_reset_defs;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        WAIT_DONE = 2'd2,
        HOLDOFF   = 2'd3
    } rx_rst_state_t;

    localparam int CNT_W = 16;

    // Statistics stop at all-ones rather than wrapping back to a misleading small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/eth_phy_10g_dn_timer.sv
// Loadable down-counter with enable and zero flag; one instance times every
// timed state of the RX reset sequencer.
module eth_phy_10g_dn_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load takes priority; the count parks at zero until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= RST_VAL;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/eth_phy_10g_rx_reset_ctrl.sv
// SERDES RX reset sequencer: hold reset, wait for done (timeout + retry), hold-off.
// Define ETH_PHY_10G_RX_RESET_STATS_EN to build the completion/timeout counters.
module eth_phy_10g_rx_reset_ctrl
    import eth_phy_10g_rx_reset_defs::*;
#(
    parameter int RESET_HOLD_CYCLES   = 64,
    parameter int DONE_TIMEOUT_CYCLES = 19531,
    parameter int HOLDOFF_CYCLES      = 156250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serdes_rx_reset_req,
    input  logic             serdes_rx_reset_done,
    output logic             serdes_rx_reset,
    output logic             rx_reset_ready,
    output logic             rx_reset_busy,
    output logic [CNT_W-1:0] rx_reset_count,
    output logic [CNT_W-1:0] rx_timeout_count
);

    localparam int MAX_AB = (RESET_HOLD_CYCLES > DONE_TIMEOUT_CYCLES) ?
                            RESET_HOLD_CYCLES : DONE_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > HOLDOFF_CYCLES) ? MAX_AB : HOLDOFF_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES) + 1;

    // Loading N-1 on entry makes each timed state last exactly N cycles.
    localparam logic [TW-1:0] HOLD_LD    = TW'(RESET_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(DONE_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] HOLDOFF_LD = TW'(HOLDOFF_CYCLES - 1);

    rx_rst_state_t state_reg;
    logic          serdes_rx_reset_reg;
    logic          ready_reg;
    logic          busy_reg;

    logic          timer_load;
    logic [TW-1:0] timer_load_value;
    logic          timer_en;
    logic          timer_zero;

    eth_phy_10g_dn_timer #(
        .W       (TW),
        .RST_VAL (HOLD_LD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .en         (timer_en),
        .zero       (timer_zero)
    );

    // Timer reloads mirror the state transitions taken in the FSM below.
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = HOLD_LD;
        timer_en         = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (serdes_rx_reset_req) begin
                    timer_load       = 1'b1;
                    timer_load_value = HOLD_LD;
                end
            end
            ASSERT: begin
                if (timer_zero) begin
                    timer_load       = 1'b1;
                    timer_load_value = TIMEOUT_LD;
                end
            end
            WAIT_DONE: begin
                if (serdes_rx_reset_done) begin
                    timer_load       = 1'b1;
                    timer_load_value = HOLDOFF_LD;
                end else if (timer_zero) begin
                    timer_load       = 1'b1;
                    timer_load_value = HOLD_LD;
                end
            end
            HOLDOFF: begin
                timer_load = 1'b0;
            end
            default: begin
                timer_load       = 1'b1;
                timer_load_value = HOLD_LD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= ASSERT;
            serdes_rx_reset_reg <= 1'b1;
            ready_reg           <= 1'b0;
            busy_reg            <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (serdes_rx_reset_req) begin
                        state_reg           <= ASSERT;
                        serdes_rx_reset_reg <= 1'b1;
                        ready_reg           <= 1'b0;
                        busy_reg            <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (timer_zero) begin
                        state_reg           <= WAIT_DONE;
                        serdes_rx_reset_reg <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    // Completion beats a coincident timeout.
                    if (serdes_rx_reset_done) begin
                        state_reg <= HOLDOFF;
                    end else if (timer_zero) begin
                        state_reg           <= ASSERT;
                        serdes_rx_reset_reg <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (timer_zero) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg           <= ASSERT;
                    serdes_rx_reset_reg <= 1'b1;
                    ready_reg           <= 1'b0;
                    busy_reg            <= 1'b1;
                end
            endcase
        end
    end

    assign serdes_rx_reset = serdes_rx_reset_reg;
    assign rx_reset_ready  = ready_reg;
    assign rx_reset_busy   = busy_reg;

`ifdef ETH_PHY_10G_RX_RESET_STATS_EN
    logic [CNT_W-1:0] reset_count_reg;
    logic [CNT_W-1:0] timeout_count_reg;
    logic             seq_done_evt;
    logic             timeout_evt;

    assign seq_done_evt = (state_reg == WAIT_DONE) && serdes_rx_reset_done;
    assign timeout_evt  = (state_reg == WAIT_DONE) && !serdes_rx_reset_done && timer_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_count_reg   <= '0;
            timeout_count_reg <= '0;
        end else begin
            if (seq_done_evt) begin
                reset_count_reg <= sat_inc(reset_count_reg);
            end
            if (timeout_evt) begin
                timeout_count_reg <= sat_inc(timeout_count_reg);
            end
        end
    end

    assign rx_reset_count   = reset_count_reg;
    assign rx_timeout_count = timeout_count_reg;
`else
    assign rx_reset_count   = '0;
    assign rx_timeout_count = '0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_reset_ctrl.sv
// Scoreboard bench: stimulus queues every expected output change (cycle + value),
// a monitor pops and compares each time the DUT outputs change.
module tb_eth_phy_10g_rx_reset_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        done = 1'b1;
    logic        serdes_rx_reset;
    logic        rx_reset_ready;
    logic        rx_reset_busy;
    logic [15:0] rx_reset_count;
    logic [15:0] rx_timeout_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [34:0] vec;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [34:0] last_pushed = '0;
    bit          any_pushed = 0;

    eth_phy_10g_rx_reset_ctrl #(
        .RESET_HOLD_CYCLES   (4),
        .DONE_TIMEOUT_CYCLES (16),
        .HOLDOFF_CYCLES      (8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .serdes_rx_reset_req  (req),
        .serdes_rx_reset_done (done),
        .serdes_rx_reset      (serdes_rx_reset),
        .rx_reset_ready       (rx_reset_ready),
        .rx_reset_busy        (rx_reset_busy),
        .rx_reset_count       (rx_reset_count),
        .rx_timeout_count     (rx_timeout_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst) cyc <= cyc + 1;

    // Count-only changes vanish when the stats counters are not built.
    task automatic push(input int c, input logic s, input logic r, input logic b,
                        input int rc, input int tc, input string name);
        logic [15:0] rcv;
        logic [15:0] tcv;
        logic [34:0] v;
`ifdef ETH_PHY_10G_RX_RESET_STATS_EN
        rcv = 16'(rc);
        tcv = 16'(tc);
`else
        rcv = 16'd0;
        tcv = 16'd0;
`endif
        v = {s, r, b, rcv, tcv};
        if (!any_pushed || v != last_pushed) begin
            exp_q.push_back('{c, v, name});
            last_pushed = v;
            any_pushed  = 1;
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: compare every output change against the head of the queue.
    initial begin : monitor
        logic [34:0] prev;
        logic [34:0] cur;
        exp_t        e;
        bit          first;
        prev  = '0;
        first = 1;
        forever begin
            @(negedge clk or posedge rst);
            #2;
            cur = {serdes_rx_reset, rx_reset_ready, rx_reset_busy, rx_reset_count, rx_timeout_count};
            if (first || cur != prev) begin
                first = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got srst=%b rdy=%b busy=%b rc=%0d tc=%0d, required no change",
                             cyc, cur[34], cur[33], cur[32], cur[31:16], cur[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec != cur) begin
                        errors++;
                        $display("FAIL %s got cyc=%0d srst=%b rdy=%b busy=%b rc=%0d tc=%0d, required cyc=%0d srst=%b rdy=%b busy=%b rc=%0d tc=%0d",
                                 e.name, cyc, cur[34], cur[33], cur[32], cur[31:16], cur[15:0],
                                 e.cyc, e.vec[34], e.vec[33], e.vec[32], e.vec[31:16], e.vec[15:0]);
                    end else begin
                        $display("ok   %s cyc=%0d srst=%b rdy=%b busy=%b rc=%0d tc=%0d",
                                 e.name, cyc, cur[34], cur[33], cur[32], cur[31:16], cur[15:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        // Power-up with done tied high.
        push(0,  1, 0, 1, 0, 0, "reset_state");
        push(4,  0, 0, 1, 0, 0, "pwrup_release");
        push(5,  0, 0, 1, 1, 0, "pwrup_done");
        push(13, 0, 1, 0, 1, 0, "pwrup_ready");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Request in IDLE; done rises on the 5th WAIT_DONE cycle.
        push(21, 1, 0, 1, 1, 0, "req_assert");
        push(25, 0, 0, 1, 1, 0, "req_release");
        push(30, 0, 0, 1, 2, 0, "req_done");
        push(38, 0, 1, 0, 2, 0, "req_ready");
        goto(15); done = 1'b0;
        goto(20); req = 1'b1;
        goto(21); req = 1'b0;
        goto(29); done = 1'b1;

        // Requests in ASSERT, WAIT_DONE, HOLDOFF and HOLDOFF exit are dropped.
        push(41, 1, 0, 1, 2, 0, "drop_assert");
        push(45, 0, 0, 1, 2, 0, "drop_release");
        push(48, 0, 0, 1, 3, 0, "drop_done");
        push(56, 0, 1, 0, 3, 0, "drop_ready");
        goto(40); done = 1'b0; req = 1'b1;
        goto(41); req = 1'b0;
        goto(42); req = 1'b1;
        goto(43); req = 1'b0;
        goto(46); req = 1'b1;
        goto(47); req = 1'b0; done = 1'b1;
        goto(50); req = 1'b1;
        goto(51); req = 1'b0;
        goto(55); req = 1'b1;
        goto(56); req = 1'b0;

        // done held low: retries every 20 cycles; done wins on the final timeout cycle.
        push(61,  1, 0, 1, 3, 0, "to_assert0");
        push(65,  0, 0, 1, 3, 0, "to_release0");
        push(81,  1, 0, 1, 3, 1, "to_retry1");
        push(85,  0, 0, 1, 3, 1, "to_release1");
        push(101, 1, 0, 1, 3, 2, "to_retry2");
        push(105, 0, 0, 1, 3, 2, "to_release2");
        push(121, 1, 0, 1, 3, 3, "to_retry3");
        push(125, 0, 0, 1, 3, 3, "to_release3");
        push(141, 0, 0, 1, 4, 3, "done_wins");
        push(149, 0, 1, 0, 4, 3, "to_ready");
        goto(58); done = 1'b0;
        goto(60); req = 1'b1;
        goto(61); req = 1'b0;
        goto(140); done = 1'b1;

        // Stale done ignored in ASSERT; async reset during HOLDOFF restarts everything.
        push(152, 1, 0, 1, 4, 3, "rst_seq_assert");
        push(156, 0, 0, 1, 4, 3, "rst_seq_release");
        push(157, 0, 0, 1, 5, 3, "rst_seq_done");
        push(160, 1, 0, 1, 0, 0, "async_reset");
        push(164, 0, 0, 1, 0, 0, "restart_release");
        push(165, 0, 0, 1, 1, 0, "restart_done");
        push(173, 0, 1, 0, 1, 0, "restart_ready");
        goto(151); req = 1'b1;
        goto(152); req = 1'b0;
        goto(160); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        goto(190);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_changes got %0d pending, required 0 (next %s at cyc %0d)",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
